heater_thermostat: RTL
======================

Name: heater_thermostat

Overview:
- Downstream consumer of the thermistor temperature converter; turns the signed integer °C reading into a heater drive decision.
- One instance per heater channel (hotend, bed).
- Closes a bang-bang loop with hysteresis around a host-supplied target.
- Latches safety faults (open sensor, overtemperature, thermal runaway) and forces the heater off until the host clears them.

Parameters:
- HYST, 2: hysteresis half-band, °C.
- MAX_TEMP, 280: overtemperature limit, °C. A reading ≥ MAX_TEMP is a fault.
- MIN_TEMP, -50: open-sensor limit, °C. A reading ≤ MIN_TEMP is a fault (the converter saturates to -55 when the sensor is open).
- REHEAT_BAND, 10: HOLD returns to HEAT when temp < target − REHEAT_BAND.
- RUNAWAY_RISE, 2: minimum rise in °C per runaway window while in HEAT.
- RUNAWAY_CYC, 1_000_000_000: runaway window in clk cycles (20 s at 50 MHz). Counter width is 32 bits.
- PWM_PERIOD, 50_000: PWM period in cycles. Used only with the optional feature.
- PWM_DUTY, 40_000: maximum on-cycles per period. Used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, synchronous, active-low.
- enable, in, 1: host heater enable.
- target, in, 12 signed: setpoint in °C. Values above MAX_TEMP − HYST are clamped internally to MAX_TEMP − HYST.
- temp, in, 12 signed: current temperature in °C from the converter stage.
- fault_clear, in, 1: single-cycle pulse; leaves FAULT.
- heater_on, out, 1: heater MOSFET drive, registered.
- at_target, out, 1: registered; high when |temp − target| ≤ HYST in HOLD.
- fault, out, 2: registered, latched fault code. 0 = none, 1 = open sensor, 2 = overtemperature, 3 = runaway.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, heater_on 0, at_target 0, fault 0, runaway counter 0, reference temperature 0.
- All inputs are evaluated every cycle. Outputs reflect the state one cycle after the inputs that caused it.
- Safety checks run in every state except FAULT. Priority is 1 > 2 > 3.
  - temp ≤ MIN_TEMP → FAULT, code 1.
  - temp ≥ MAX_TEMP → FAULT, code 2.
  - Safety faults override enable and all transitions.
- IDLE: heater_on 0, at_target 0.
  - If enable=1 and temp < target − HYST → HEAT.
  - Else if enable=1 → HOLD.
- HEAT: heater_on 1.
  - On entry: ref ← temp, counter ← 0.
  - Each cycle counter increments.
  - If temp ≥ ref + RUNAWAY_RISE: ref ← temp, counter ← 0.
  - If counter reaches RUNAWAY_CYC−1 without a rise → FAULT, code 3.
  - temp ≥ target → HOLD.
- HOLD:
  - heater_on is set when temp < target − HYST and cleared when temp ≥ target; otherwise it holds its value.
  - at_target = (temp ≥ target − HYST) and (temp ≤ target + HYST).
  - temp < target − REHEAT_BAND → HEAT (runaway reference re-armed).
- enable=0 in HEAT or HOLD → IDLE; heater_on is 0 on the next cycle.
- A target change while in HOLD takes effect through the same comparisons on the next cycle. No state reset.
- FAULT: heater_on 0, at_target 0, fault holds its code.
  - fault_clear=1 and no fault condition present that cycle → IDLE, fault ← 0.
  - If fault_clear coincides with an active fault condition, the module stays in FAULT and the code updates to the highest-priority active condition.
- Comparisons are signed, 13-bit to avoid overflow on target ± band.
- rst_n low mid-operation returns everything to reset values on that edge, including a latched fault.

Optional Feature:
- Macro: HEATER_PWM_EN.
- Defined: heater_on is the control decision ANDed with a free-running PWM gate.
  - Period counter runs 0..PWM_PERIOD−1; gate = (counter < PWM_DUTY).
  - The counter resets to 0 on rst_n.
  - The runaway timer still counts every cycle.
- Not defined: heater_on is the raw decision. No PWM counter is synthesized.

Test Plan:
- Bench parameters for all scenarios: RUNAWAY_CYC=100, HYST=2, MAX_TEMP=280.
- Heat and hold: reset, enable=1, target=200, temp=25.
  - Expect heater_on=1 one cycle later, state HEAT.
  - Ramp temp +3 every 50 cycles to 200 → heater_on=0, at_target=1.
  - Drop temp to 197 → heater_on=1; raise to 200 → heater_on=0.
- Runaway: target=200, temp held at 25 in HEAT → fault=3 after 100 cycles, heater_on=0. fault_clear with temp=25 → IDLE, fault=0.
- Open sensor: temp=-55 while in HOLD → fault=1 next cycle. fault_clear while temp=-55 → fault stays 1. temp=25 plus fault_clear → fault=0.
- Overtemp and clamp:
  - target=300 → internal target 278.
  - temp=280 → fault=2.
  - Simultaneous temp=-55 forces code 1 (priority check).
- Disable and reset mid-HEAT: enable→0 → heater_on=0 next cycle, IDLE. Re-enable, then assert rst_n=0 mid-HEAT → all outputs 0.
- HEATER_PWM_EN with PWM_PERIOD=10, PWM_DUTY=4: in HEAT, heater_on is high for 4 of every 10 cycles; it is 0 throughout FAULT.

Source files
------------

// File: rtl/heater_thermostat.sv
`default_nettype none
// ============================================================================
// Module   : heater_thermostat
// Brief    : Bang-bang heater control with hysteresis and latched safety faults.
//            Optional macro HEATER_PWM_EN gates the heater drive with a PWM.
// Revision : 1.0 - initial release
// ============================================================================
module heater_thermostat #(
    parameter int HYST         = 2,
    parameter int MAX_TEMP     = 280,
    parameter int MIN_TEMP     = -50,
    parameter int REHEAT_BAND  = 10,
    parameter int RUNAWAY_RISE = 2,
    parameter int RUNAWAY_CYC  = 1_000_000_000,
    parameter int PWM_PERIOD   = 50_000,
    parameter int PWM_DUTY     = 40_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] target,
    input  logic [11:0] temp,
    input  logic        fault_clear,
    output logic        heater_on,
    output logic        at_target,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HEAT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic signed [12:0] c_hyst     = 13'(HYST);
    localparam logic signed [12:0] c_max      = 13'(MAX_TEMP);
    localparam logic signed [12:0] c_min      = 13'(MIN_TEMP);
    localparam logic signed [12:0] c_reheat   = 13'(REHEAT_BAND);
    localparam logic signed [12:0] c_rise     = 13'(RUNAWAY_RISE);
    localparam logic signed [12:0] c_tgt_lim  = 13'(MAX_TEMP - HYST);
    localparam logic [31:0]        c_run_last = 32'(RUNAWAY_CYC - 1);

    localparam logic [1:0] c_code_none    = 2'd0;
    localparam logic [1:0] c_code_open    = 2'd1;
    localparam logic [1:0] c_code_over    = 2'd2;
    localparam logic [1:0] c_code_runaway = 2'd3;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_heater;
    logic               w_heater_next;
    logic               r_at;
    logic               w_at_next;
    logic [1:0]         r_fault;
    logic [1:0]         w_fault_next;
    logic signed [12:0] r_ref;
    logic signed [12:0] w_ref_next;
    logic [31:0]        r_cnt;
    logic [31:0]        w_cnt_next;
    logic               w_arm;

    logic signed [12:0] w_temp;
    logic signed [12:0] w_target;
    logic signed [12:0] w_tgt;
    logic signed [12:0] w_tgt_lo;
    logic signed [12:0] w_tgt_hi;
    logic signed [12:0] w_tgt_reheat;
    logic               w_open;
    logic               w_over;
    logic               w_rise;

    // Sign-extend to 13 bits so target +/- band cannot wrap.
    assign w_temp       = {temp[11], temp};
    assign w_target     = {target[11], target};
    assign w_tgt        = (w_target > c_tgt_lim) ? c_tgt_lim : w_target;
    assign w_tgt_lo     = w_tgt - c_hyst;
    assign w_tgt_hi     = w_tgt + c_hyst;
    assign w_tgt_reheat = w_tgt - c_reheat;
    assign w_open       = (w_temp <= c_min);
    assign w_over       = (w_temp >= c_max);
    assign w_rise       = (w_temp >= (r_ref + c_rise));

    always_comb begin
        w_state_next  = r_state;
        w_fault_next  = r_fault;
        w_ref_next    = r_ref;
        w_cnt_next    = r_cnt;
        w_heater_next = 1'b0;
        w_at_next     = 1'b0;
        w_arm         = 1'b0;

        if (r_state != S_FAULT && w_open) begin
            w_state_next = S_FAULT;
            w_fault_next = c_code_open;
        end else if (r_state != S_FAULT && w_over) begin
            w_state_next = S_FAULT;
            w_fault_next = c_code_over;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (w_temp < w_tgt_lo) begin
                            w_state_next = S_HEAT;
                            w_arm        = 1'b1;
                        end else begin
                            w_state_next = S_HOLD;
                        end
                    end
                end
                S_HEAT: begin
                    if (!enable) begin
                        w_state_next = S_IDLE;
                    end else if (w_temp >= w_tgt) begin
                        w_state_next = S_HOLD;
                    end else if (w_rise) begin
                        w_ref_next = w_temp;
                        w_cnt_next = 32'd0;
                    end else if (r_cnt == c_run_last) begin
                        w_state_next = S_FAULT;
                        w_fault_next = c_code_runaway;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                S_HOLD: begin
                    if (!enable) begin
                        w_state_next = S_IDLE;
                    end else if (w_temp < w_tgt_reheat) begin
                        w_state_next = S_HEAT;
                        w_arm        = 1'b1;
                    end
                end
                S_FAULT: begin
                    // A clear only succeeds once no live condition remains.
                    if (fault_clear) begin
                        if (w_open) begin
                            w_fault_next = c_code_open;
                        end else if (w_over) begin
                            w_fault_next = c_code_over;
                        end else begin
                            w_state_next = S_IDLE;
                            w_fault_next = c_code_none;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        if (w_arm) begin
            w_ref_next = w_temp;
            w_cnt_next = 32'd0;
        end

        case (w_state_next)
            S_HEAT: w_heater_next = 1'b1;
            S_HOLD: begin
                if (w_temp < w_tgt_lo) begin
                    w_heater_next = 1'b1;
                end else if (w_temp >= w_tgt) begin
                    w_heater_next = 1'b0;
                end else begin
                    w_heater_next = r_heater;
                end
                w_at_next = (w_temp >= w_tgt_lo) && (w_temp <= w_tgt_hi);
            end
            default: begin
                w_heater_next = 1'b0;
                w_at_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_heater <= 1'b0;
            r_at     <= 1'b0;
            r_fault  <= c_code_none;
            r_ref    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_heater <= w_heater_next;
            r_at     <= w_at_next;
            r_fault  <= w_fault_next;
            r_ref    <= w_ref_next;
            r_cnt    <= w_cnt_next;
        end
    end

    assign at_target = r_at;
    assign fault     = r_fault;

`ifdef HEATER_PWM_EN
    localparam int          c_pwm_w    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [c_pwm_w-1:0] c_pwm_last = c_pwm_w'(PWM_PERIOD - 1);
    localparam logic [c_pwm_w:0]   c_pwm_duty = (c_pwm_w + 1)'(PWM_DUTY);

    logic [c_pwm_w-1:0] r_pwm_cnt;
    logic [c_pwm_w-1:0] w_pwm_cnt_next;
    logic               r_pwm_on;

    assign w_pwm_cnt_next = (r_pwm_cnt == c_pwm_last) ? '0 : r_pwm_cnt + 1'b1;

    // The gate is evaluated on the counter's next value so the drive stays a single flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_pwm_on  <= 1'b0;
        end else begin
            r_pwm_cnt <= w_pwm_cnt_next;
            r_pwm_on  <= w_heater_next && ({1'b0, w_pwm_cnt_next} < c_pwm_duty);
        end
    end

    assign heater_on = r_pwm_on;
`else
    assign heater_on = r_heater;
`endif

endmodule
`default_nettype wire
